// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: icache/ibuf credit inputs, redirect request,
// fetch group outputs, flush pulse and stall statistics.
interface fetch_sequencer_if #(
    parameter int PC_W      = 16,
    parameter int ROB_IDX_W = 4,
    parameter int CNT_W     = 3
);
    logic [3:0]           ibuf_free;
    logic [ROB_IDX_W:0]   rob_free;
    logic                 redirect_valid;
    logic [PC_W-1:0]      redirect_pc;
    logic [ROB_IDX_W-1:0] redirect_rob_idx;
    logic                 fetch_valid;
    logic [PC_W-1:0]      fetch_pc;
    logic [CNT_W-1:0]     fetch_count;
    logic [ROB_IDX_W-1:0] fetch_rob_base;
    logic                 flush;
    logic [15:0]          stall_cycles;

    modport master (
        input  ibuf_free, rob_free,
        input  redirect_valid, redirect_pc, redirect_rob_idx,
        output fetch_valid, fetch_pc, fetch_count, fetch_rob_base,
        output flush, stall_cycles
    );

    modport slave (
        output ibuf_free, rob_free,
        output redirect_valid, redirect_pc, redirect_rob_idx,
        input  fetch_valid, fetch_pc, fetch_count, fetch_rob_base,
        input  flush, stall_cycles
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns fetch PC and ROB tail, grants up to
// FETCH_WIDTH lanes per cycle, handles redirects with a one-cycle flush.
// Ports: clk, rst_n (async active-low), bus (fetch_sequencer_if.master).
module fetch_sequencer #(
    parameter int              FETCH_WIDTH = 4,
    parameter int              PC_W        = 16,
    parameter int              ROB_IDX_W   = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        REDIRECT
    } state_t;

    state_t               state, state_d;
    logic [PC_W-1:0]      pc, pc_d;
    logic [ROB_IDX_W-1:0] rob_tail, tail_d;
    logic                 valid_q, valid_d;
    logic [PC_W-1:0]      fpc_q, fpc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROB_IDX_W-1:0] base_q, base_d;
    logic                 flush_q, flush_d;
    logic [15:0]          stall_q, stall_d;

    logic [ROB_IDX_W:0]   lim;
    logic [CNT_W-1:0]     grant;

    // grant = min(FETCH_WIDTH, ibuf_free, rob_free)
    always_comb begin
        lim = (ROB_IDX_W + 1)'(FETCH_WIDTH);
        if ((ROB_IDX_W + 1)'(bus.ibuf_free) < lim)
            lim = (ROB_IDX_W + 1)'(bus.ibuf_free);
        if (bus.rob_free < lim)
            lim = bus.rob_free;
        grant = CNT_W'(lim);
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        tail_d  = rob_tail;
        valid_d = valid_q;
        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        flush_d = 1'b0;
        stall_d = stall_q;

        if (state == STALL && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;

        if (bus.redirect_valid) begin
            // redirect beats everything; ROB resumes after the branch
            pc_d    = {bus.redirect_pc[PC_W-1:1], 1'b0};
            tail_d  = bus.redirect_rob_idx + ROB_IDX_W'(1);
            valid_d = 1'b0;
            cnt_d   = '0;
            flush_d = 1'b1;
            state_d = REDIRECT;
        end else begin
            case (state)
                BOOT: begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
                default: begin
                    if (grant != '0) begin
                        valid_d = 1'b1;
                        fpc_d   = pc;
                        cnt_d   = grant;
                        base_d  = rob_tail;
                        pc_d    = pc + PC_W'({grant, 1'b0});
                        tail_d  = rob_tail + ROB_IDX_W'(grant);
                        state_d = RUN;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = STALL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            rob_tail <= '0;
            valid_q  <= 1'b0;
            fpc_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            flush_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            rob_tail <= tail_d;
            valid_q  <= valid_d;
            fpc_q    <= fpc_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            flush_q  <= flush_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.fetch_valid    = valid_q;
    assign bus.fetch_pc       = fpc_q;
    assign bus.fetch_count    = cnt_q;
    assign bus.fetch_rob_base = base_q;
    assign bus.flush          = flush_q;
    assign bus.stall_cycles   = stall_q;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the front-end fetch stage. Owns the architectural fetch PC and decides each cycle how many instructions (0..FETCH_WIDTH) to request from the icache, limited by instruction-buffer credits and free ROB slots. Allocates the ROB base index that the decode dependency logic uses for owner tags. Handles branch redirects with a one-cycle flush bubble and ROB tail rewind.

Parameters:
FETCH_WIDTH, 4, max instructions fetched per cycle (lanes); PCs are fetch_pc + 2*lane.
PC_W, 16, PC width; byte addressed, 16-bit instructions.
ROB_IDX_W, 4, ROB index width; ROB depth = 2**ROB_IDX_W.
RESET_PC, 16'h0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
ibuf_free  in  4  free instruction-buffer slots this cycle.
rob_free  in  5  free ROB entries this cycle (0..16).
redirect_valid  in  1  branch unit redirect request (one-cycle pulse).
redirect_pc  in  PC_W  redirect target; bit 0 ignored (forced 0).
redirect_rob_idx  in  ROB_IDX_W  ROB index of the redirecting branch.
fetch_valid  out  1  fetch group valid this cycle (registered).
fetch_pc  out  PC_W  PC of lane 0 (registered).
fetch_count  out  3  lanes valid, 0..FETCH_WIDTH (registered).
fetch_rob_base  out  ROB_IDX_W  ROB index for lane 0; lane i gets base+i mod depth.
flush  out  1  one-cycle pulse: squash the decode register and all younger work.
stall_cycles  out  16  saturating count of cycles spent in STALL.

Behaviour:
- Reset (rst_n=0, async): state=BOOT, pc=RESET_PC, rob_tail=0, fetch_valid=0, fetch_pc=0, fetch_count=0, fetch_rob_base=0, flush=0, stall_cycles=0.
- Combinational grant n = min(FETCH_WIDTH, ibuf_free, rob_free).
- States: BOOT, RUN, STALL, REDIRECT.
- BOOT: outputs idle; next posedge goes to RUN (no fetch in BOOT). The first fetch group appears at the second posedge after rst_n rises.
- RUN/STALL, no redirect, n>0: fetch_valid<=1, fetch_pc<=pc, fetch_count<=n, fetch_rob_base<=rob_tail; pc<=pc+2n (mod 2**PC_W); rob_tail<=rob_tail+n (mod depth); state<=RUN. Fetch latency is 1 cycle from grant to outputs.
- RUN/STALL, no redirect, n==0: fetch_valid<=0, fetch_count<=0, pc and rob_tail held, state<=STALL. stall_cycles increments each cycle state==STALL and saturates at 16'hFFFF.
- Redirect (any state, including BOOT) has highest priority:
  - pc<=redirect_pc & ~1.
  - rob_tail<=redirect_rob_idx+1 (mod depth).
  - fetch_valid<=0, fetch_count<=0.
  - flush<=1; state<=REDIRECT.
- REDIRECT: flush<=0. Behaves like RUN for the grant, so fetching resumes from the new pc in the next cycle (exactly one bubble). A further redirect in REDIRECT restarts the sequence; the latest redirect wins.
- flush is high for exactly one cycle per accepted redirect. Back-to-back redirects keep it high on consecutive cycles.
- fetch_pc/fetch_rob_base hold their last values while fetch_valid=0.
- Wrap: pc at 16'hFFFE + 2 wraps to 16'h0000. rob_tail 15 + 3 wraps to 2. Neither wrap is an error.
- ibuf_free or rob_free above FETCH_WIDTH is clamped by the min.
- Reset asserted mid-stream forces all state to reset values immediately. Any pending redirect is discarded.

Test Plan:
1. Reset release, ibuf_free=8, rob_free=16: no fetch in BOOT; then groups pc=0,8,16 with count=4 and rob_base=0,4,8 on consecutive cycles.
2. Credit limit: ibuf_free=2, rob_free=16 -> count=2, pc advances by 4. Then rob_free=1 -> count=1. Then ibuf_free=0 -> fetch_valid=0, state STALL. stall_cycles counts 3 after 3 stalled cycles; resume when ibuf_free=4.
3. Redirect pulse with redirect_pc=0x0101, redirect_rob_idx=5 mid-stream:
   - next cycle: flush=1, fetch_valid=0.
   - following cycle: fetch_pc=0x0100, fetch_rob_base=6, flush=0.
4. Redirect on two consecutive cycles (targets 0x40 then 0x80) -> flush high 2 cycles; the first resumed fetch is pc=0x80.
5. Wrap: redirect to 0xFFF8 with rob_idx=13, full credits -> groups pc=0xFFF8 (rob_base 14), then pc=0x0000 (rob_base 2).
6. Assert rst_n low during STALL with stall_cycles=10 -> all outputs zero asynchronously; after release, the first fetch pc=RESET_PC and rob_base=0.
